// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_AW            = 8;
  localparam int DEF_DW            = 8;
  localparam int DEF_HOST_WAIT_MAX = 4;
  localparam int DEF_MAX_BURST     = 8;
  localparam int DEF_CNT_W         = 16;

  // FSM register: which requester owned memory in the previous cycle
  typedef enum logic [1:0] {
    IDLE,
    CORE,
    HOST,
    RELEASE
  } arb_state_t;

  // Combinational grant decision for the current cycle
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_HOST
  } owner_t;

  // Bits needed to hold values 0..max_val, never less than one bit
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at MAX_VAL.
module arb_sat_counter #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear wins over increment; increment stops at the ceiling
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the core datapath and
// a host loader/debug port. Core has default priority; a host kept waiting
// for HOST_WAIT_MAX cycles is forced in, and h_lock bursts are capped at
// MAX_BURST grants before one cycle is offered back to the core.
// Optional build macro ARB_STATS_EN adds saturating stall/host-grant counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW            = DEF_AW,
  parameter int DW            = DEF_DW,
  parameter int HOST_WAIT_MAX = DEF_HOST_WAIT_MAX,
  parameter int MAX_BURST     = DEF_MAX_BURST
`ifdef ARB_STATS_EN
  ,
  parameter int CNT_W         = DEF_CNT_W
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          core_stall,
  input  logic          h_req,
  input  logic          h_we,
  input  logic          h_lock,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] host_cnt
`endif
);

  localparam int WAIT_W  = cnt_width(HOST_WAIT_MAX);
  localparam int BURST_W = cnt_width(MAX_BURST);
  localparam logic [WAIT_W-1:0]  WAIT_MAX_V  = WAIT_W'(HOST_WAIT_MAX);
  localparam logic [BURST_W-1:0] BURST_MAX_V = BURST_W'(MAX_BURST);

  arb_state_t         state_q;
  owner_t             owner;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_base;
  logic [BURST_W-1:0] burst_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               core_grant;
  logic               host_grant;

  // Per-cycle grant, first matching rule wins; nothing is granted in reset
  always_comb begin
    owner = OWN_NONE;
    if (reset) begin
      owner = OWN_NONE;
    end else if ((state_q == HOST) && h_req && (burst_cnt < BURST_MAX_V)) begin
      owner = OWN_HOST;
    end else if ((state_q == RELEASE) && c_req) begin
      owner = OWN_CORE;
    end else if (c_req && (wait_cnt < WAIT_MAX_V)) begin
      owner = OWN_CORE;
    end else if (h_req) begin
      owner = OWN_HOST;
    end
  end

  assign core_grant = (owner == OWN_CORE);
  assign host_grant = (owner == OWN_HOST);

  // A host grant outside HOST starts a fresh burst, so count from zero there
  assign burst_base = (state_q == HOST) ? burst_cnt : '0;
  assign burst_next = burst_base + BURST_W'(1);

  // Owner FSM and burst length tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      burst_cnt <= '0;
    end else if (host_grant) begin
      burst_cnt <= burst_next;
      if (h_lock && (burst_next < BURST_MAX_V)) begin
        state_q <= HOST;
      end else if (h_lock && (burst_next == BURST_MAX_V)) begin
        state_q <= RELEASE;
      end else begin
        state_q <= IDLE;
      end
    end else begin
      burst_cnt <= '0;
      state_q   <= core_grant ? CORE : IDLE;
    end
  end

  // Cycles the host has waited for an ack; saturating at the force-in threshold
  arb_sat_counter #(
    .WIDTH  (WAIT_W),
    .MAX_VAL(WAIT_MAX_V)
  ) u_wait_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (host_grant),
    .inc  (h_req && !host_grant),
    .count(wait_cnt)
  );

  assign core_stall = c_req && !core_grant && !reset;
  assign h_ack      = host_grant;
  assign c_rdata    = m_rdata;
  assign h_rdata    = m_rdata;

  // Steer the granted requester onto the memory port; idle port never writes
  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    case (owner)
      OWN_CORE: begin
        m_we    = c_we;
        m_addr  = c_addr;
        m_wdata = c_wdata;
      end
      OWN_HOST: begin
        m_we    = h_we;
        m_addr  = h_addr;
        m_wdata = h_wdata;
      end
      default: begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
      end
    endcase
  end

`ifdef ARB_STATS_EN
  // Cycles in which the core was held off
  arb_sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .inc  (core_stall),
    .count(stall_cnt)
  );

  // Accesses granted to the host
  arb_sat_counter #(
    .WIDTH(CNT_W)
  ) u_host_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .inc  (host_grant),
    .count(host_cnt)
  );
`endif

endmodule
